// File: rtl/vga_scanout_if.sv
// Framebuffer read port and VGA output bundle for vga_scanout.
// master: the scanout engine. slave: framebuffer memory / display sink.
interface vga_scanout_if;
    logic [18:0] ram_read_address;
    logic [2:0]  ram_read_data;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_de;
    logic        frame_start;

    modport master (
        output ram_read_address,
        input  ram_read_data,
        output vga_r, vga_g, vga_b,
        output vga_hsync, vga_vsync, vga_de, frame_start
    );

    modport slave (
        input  ram_read_address,
        output ram_read_data,
        input  vga_r, vga_g, vga_b,
        input  vga_hsync, vga_vsync, vga_de, frame_start
    );
endinterface

// File: rtl/vga_scanout.sv
// VGA scanout: 25 MHz pixel timing from a 50 MHz clock, 320x240 3-bit
// framebuffer shown pixel-doubled on a 640x480 raster.
// Optional macro VGA_SCANLINE_EN dims set bits on odd output lines to 4'h7.
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic          clock,
    input  logic          reset,
    vga_scanout_if.master bus
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = 19;
    localparam int FB_W    = H_VISIBLE / 2;

    logic          pix_en;
    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic          visible;
    logic          hs_act;
    logic          vs_act;
    logic [3:0]    lvl;
    logic [3:0]    r_q, g_q, b_q;
    logic          hs_q, vs_q, de_q, fs_q;

    // Pixel enable: half-rate strobe, low on the first clock after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) pix_en <= 1'b0;
        else       pix_en <= ~pix_en;
    end

    // Raster counters, stepping once per pixel period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (pix_en) begin
            if (hc == HW'(H_TOTAL - 1)) begin
                hc <= '0;
                vc <= (vc == VW'(V_TOTAL - 1)) ? '0 : vc + VW'(1);
            end else begin
                hc <= hc + HW'(1);
            end
        end
    end

    // Raster decode and framebuffer address (2x2 pixel doubling).
    always_comb begin
        visible = (hc < HW'(H_VISIBLE)) && (vc < VW'(V_VISIBLE));
        hs_act  = (hc >= HW'(H_VISIBLE + H_FRONT)) &&
                  (hc <  HW'(H_VISIBLE + H_FRONT + H_SYNC));
        vs_act  = (vc >= VW'(V_VISIBLE + V_FRONT)) &&
                  (vc <  VW'(V_VISIBLE + V_FRONT + V_SYNC));
`ifdef VGA_SCANLINE_EN
        // vc captured here becomes the line the output registers show.
        lvl     = vc[0] ? 4'h7 : 4'hF;
`else
        lvl     = 4'hF;
`endif
        bus.ram_read_address = visible
            ? (AW'(FB_W) * AW'(vc >> 1)) + AW'(hc >> 1)
            : '0;
    end

    // Output registers: capture the ending pixel period and its RAM data,
    // so sync, DE and colour stay aligned two clocks behind the counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q  <= 4'h0;
            g_q  <= 4'h0;
            b_q  <= 4'h0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            de_q <= 1'b0;
        end else if (pix_en) begin
            r_q  <= (visible && bus.ram_read_data[2]) ? lvl : 4'h0;
            g_q  <= (visible && bus.ram_read_data[1]) ? lvl : 4'h0;
            b_q  <= (visible && bus.ram_read_data[0]) ? lvl : 4'h0;
            hs_q <= ~hs_act;
            vs_q <= ~vs_act;
            de_q <= visible;
        end
    end

    // Frame start pulse: set on the step into the first blanking line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) fs_q <= 1'b0;
        else       fs_q <= pix_en && (hc == HW'(H_TOTAL - 1)) &&
                           (vc == VW'(V_VISIBLE - 1));
    end

    assign bus.vga_r       = r_q;
    assign bus.vga_g       = g_q;
    assign bus.vga_b       = b_q;
    assign bus.vga_hsync   = hs_q;
    assign bus.vga_vsync   = vs_q;
    assign bus.vga_de      = de_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full-size instance and a miniature-timing
// instance run side by side against a pixel-index reference model.
module tb_vga_scanout;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #10 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    vga_scanout_if ifa();
    vga_scanout_if ifb();

    vga_scanout dut_a (.clock(clock), .reset(reset), .bus(ifa));
    vga_scanout #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(8),  .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) dut_b (.clock(clock), .reset(reset), .bus(ifb));

    logic [2:0] mem_a [76800];
    logic [2:0] mem_b [32];

    // Framebuffers with one-clock read latency
    always @(posedge clock) begin
        ifa.ram_read_data <= (ifa.ram_read_address < 19'd76800) ? mem_a[ifa.ram_read_address] : 3'b000;
        ifb.ram_read_data <= (ifb.ram_read_address < 19'd32) ? mem_b[ifb.ram_read_address[4:0]] : 3'b000;
    end

    typedef struct packed {
        logic [18:0] addr;
        logic [3:0]  r, g, b;
        logic        hs, vs, de, fs;
    } exp_t;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Expected outputs k clock edges after reset release. Pixel period n=k/2
    // is on the counters; outputs show pixel period k/2-1 from k=2 on.
    function automatic exp_t model(int k, bit big);
        int hv, hf, hs, hb, vv, vf, vs, vb, ht, vt, fbw, n, q, h, v;
        logic [2:0] d;
        logic [3:0] lvl;
        exp_t e;
        if (big) begin
            hv = 640; hf = 16; hs = 96; hb = 48; vv = 480; vf = 10; vs = 2; vb = 33;
        end else begin
            hv = 16;  hf = 2;  hs = 3;  hb = 3;  vv = 8;   vf = 1;  vs = 2; vb = 2;
        end
        ht = hv + hf + hs + hb; vt = vv + vf + vs + vb; fbw = hv / 2;
        n = k / 2;
        h = n % ht; v = (n / ht) % vt;
        e.addr = (h < hv && v < vv) ? 19'(fbw * (v / 2) + h / 2) : 19'd0;
        e.fs = (k > 0) && (k % 2 == 0) && (n % (ht * vt) == ht * vv);
        e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
        e.r = 4'h0; e.g = 4'h0; e.b = 4'h0;
        if (k >= 2) begin
            q = n - 1; h = q % ht; v = (q / ht) % vt;
            e.de = (h < hv && v < vv);
            e.hs = !(h >= hv + hf && h < hv + hf + hs);
            e.vs = !(v >= vv + vf && v < vv + vf + vs);
`ifdef VGA_SCANLINE_EN
            lvl = (v % 2 == 1) ? 4'h7 : 4'hF;
`else
            lvl = 4'hF;
`endif
            if (e.de) begin
                d = big ? mem_a[fbw * (v / 2) + h / 2] : mem_b[fbw * (v / 2) + h / 2];
                e.r = d[2] ? lvl : 4'h0;
                e.g = d[1] ? lvl : 4'h0;
                e.b = d[0] ? lvl : 4'h0;
            end
        end
        return e;
    endfunction

    exp_t qa[$];
    exp_t qb[$];
    int   ka = 0;
    int   kb = 0;

    // Stimulus side of the scoreboard: one expectation per clock edge
    always @(posedge clock) begin
        if (reset) begin ka = 0; kb = 0; end
        else begin ka++; kb++; end
        qa.push_back(model(ka, 1'b1));
        qb.push_back(model(kb, 1'b0));
    end

    // Monitor: pop and compare away from the active edge
    always @(negedge clock) begin
        exp_t e, a;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            if (reset) e = model(0, 1'b1);
            a = {ifa.ram_read_address, ifa.vga_r, ifa.vga_g, ifa.vga_b,
                 ifa.vga_hsync, ifa.vga_vsync, ifa.vga_de, ifa.frame_start};
            check("scan_a {addr,r,g,b,hs,vs,de,fs}", 64'(a), 64'(e));
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            if (reset) e = model(0, 1'b0);
            a = {ifb.ram_read_address, ifb.vga_r, ifb.vga_g, ifb.vga_b,
                 ifb.vga_hsync, ifb.vga_vsync, ifb.vga_de, ifb.frame_start};
            check("scan_b {addr,r,g,b,hs,vs,de,fs}", 64'(a), 64'(e));
        end
    end

    // Pulse width / period trackers on active-low signals:
    // 0: A hsync, 1: B vsync, 2: B frame_start (inverted)
    int  cyc = 0;
    int  last [3] = '{-1, -1, -1};
    int  lo   [3] = '{0, 0, 0};
    bit  on   [3] = '{0, 0, 0};
    bit  prev [3] = '{1, 1, 1};
    int  want_lo  [3] = '{192, 96, 1};
    int  want_per [3] = '{1600, 624, 624};
    string nm [3] = '{"hsync_a", "vsync_b", "frame_start_b"};

    always @(negedge clock) begin
        bit s [3];
        s[0] = ifa.vga_hsync; s[1] = ifb.vga_vsync; s[2] = ~ifb.frame_start;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                last[i] = -1; on[i] = 0; prev[i] = 1; lo[i] = 0;
            end else begin
                if (!s[i] && prev[i]) begin
                    if (last[i] >= 0) check({nm[i], "_period"}, 64'(cyc - last[i]), 64'(want_per[i]));
                    last[i] = cyc; lo[i] = 0; on[i] = 1;
                end
                if (!s[i] && on[i]) lo[i]++;
                if (s[i] && !prev[i] && on[i]) begin
                    check({nm[i], "_low"}, 64'(lo[i]), 64'(want_lo[i]));
                    on[i] = 0;
                end
                prev[i] = s[i];
            end
        end
    end

    initial begin
        for (int i = 0; i < 76800; i++) mem_a[i] = 3'($urandom);
        for (int i = 0; i < 32; i++)    mem_b[i] = 3'($urandom);
        mem_a[0]     = 3'b100;
        mem_a[319]   = 3'b011;
        mem_a[76799] = 3'b110;
        mem_b[0]     = 3'b111;
        mem_b[31]    = 3'b110;

        reset = 1'b1;
        repeat (10) @(posedge clock);
        #3 reset = 1'b0;
        repeat (5000) @(posedge clock);

        // Mid-line, mid-frame reset of random length
        repeat ($urandom_range(0, 1500)) @(posedge clock);
        #3 reset = 1'b1;
        repeat ($urandom_range(1, 6)) @(posedge clock);
        #3 reset = 1'b0;
        repeat (5000) @(posedge clock);

        @(negedge clock);
        #1;
        check("queue_a_drain", 64'(qa.size()), 64'd0);
        check("queue_b_drain", 64'(qb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
